dice_roll_ctrl: RTL and testbench
=================================

// Module: dice_roll_ctrl
// PURPOSE
//   Replaces the Sw-driven dice sum with an electronic dice roller sequencing the craps fsm input.
//   Spins two 1..6 dice counters while the debounced roll button is held, freezes them on release,
//   holds a settle delay timed by Clk1KHzEn, then presents DiceSum with a 1-cycle DiceRolled pulse.
//   Sits between the debounce stage and fsm; Die1/Die2 feed the seven-segment Data bus.
// PARAMETERS
//   SETTLE_MS  250  number of Clk1KHzEn ticks spent in SETTLE; legal range 1..4095
// PORTS
//   Clk100MHz   in   1  system clock, all logic on rising edge
//   reset       in   1  asynchronous, active-high reset
//   Clk1KHzEn   in   1  1-cycle enable pulse at 1 kHz
//   RollBtn     in   1  synchronised, debounced button level, 1 = pressed
//   GameReady   in   1  fsm can accept a roll; sampled only in IDLE
//   Die1        out  3  displayed die 1 value, 0 = blank, else 1..6
//   Die2        out  3  displayed die 2 value, 0 = blank, else 1..6
//   DiceSum     out  4  Die1+Die2 of last completed roll, 2..12; held until next roll completes
//   DiceRolled  out  1  1-cycle pulse, DiceSum valid on the same cycle
//   Busy        out  1  high in SPIN, SETTLE, DONE
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; Die1=Die2=0; DiceSum=0; DiceRolled=0; Busy=0;
//     spin counters c1=c2=1; settle counter=0; btn_prev=1, so a button held through reset is not a press.
//   Press = RollBtn==1 && btn_prev==0; btn_prev<=RollBtn every cycle in every state.
//   States:
//   IDLE: Busy=0. On press && GameReady -> SPIN next cycle. A press with GameReady=0 is discarded,
//     not queued.
//   SPIN: Busy=1.
//     - Each edge with RollBtn==1: c1 advances 1->2..6->1; c2 advances only on the cycle c1 wraps 6->1
//       (c2 also wraps 6->1). Each pair visited once per 36 increments.
//     - On each Clk1KHzEn in SPIN: Die1<=c1, Die2<=c2 (tumble display).
//     - Edge with RollBtn==0: Die1<=c1, Die2<=c2 (final, no increment that cycle); settle counter<=0;
//       -> SETTLE. Held indefinitely = stays in SPIN.
//   SETTLE: Busy=1. Die1/Die2 frozen. Counter++ on each Clk1KHzEn.
//     - On the tick bringing counter to SETTLE_MS -> DONE.
//     - RollBtn ignored except for btn_prev tracking.
//   DONE (1 cycle): DiceSum<=Die1+Die2 (3b+3b zero-extended to 4b, max 12, no overflow);
//     DiceRolled=1 this cycle only; Busy=1; -> IDLE.
//   DiceRolled registered: high exactly the cycle state==DONE.
//   c1/c2 persist across rolls; only reset clears them.
//   Press arriving during SETTLE/DONE and still held on return to IDLE does not start a roll;
//     user must release and press again.
//   GameReady dropping after SPIN entered has no effect on the roll in progress.
//   Latency:
//     - press edge -> SPIN: 1 cycle.
//     - release -> DiceRolled: SETTLE_MS ticks plus 1 cycle.
//   Reset mid-operation aborts the roll: no DiceRolled, outputs return to reset values.
// TESTING
//   T1 reset/idle: assert reset with RollBtn=1 and release it -> Die1=Die2=DiceSum=0, Busy=0;
//      no SPIN until RollBtn falls then rises.
//   T2 basic roll (SETTLE_MS=2): from reset, 8 SPIN cycles with RollBtn=1, then release
//      -> Die1=3, Die2=2; after 2 Clk1KHzEn ticks DiceRolled=1 for 1 cycle, DiceSum=5.
//   T3 max sum: from reset, 35 increments -> Die1=6, Die2=6, DiceSum=12 (4'hC);
//      next roll of 1 increment -> (1,1), DiceSum=2.
//   T4 gating: GameReady=0 at press -> stays IDLE, Busy=0, no DiceRolled;
//      raising GameReady while still held does not start a roll.
//   T5 re-press in SETTLE: press during SETTLE -> ignored, exactly one DiceRolled,
//      IDLE with button held -> no new roll.
//   T6 reset mid-SETTLE: assert reset -> DiceRolled never pulses, Die1=Die2=DiceSum=0, c1=c2=1.

Source files
------------

// File: rtl/dice_roll_ctrl.sv
// Electronic dice roller: spins two 1..6 counters while the roll button is held,
// freezes them on release, waits a settle delay, then reports the sum with a pulse.
module dice_roll_ctrl #(
   parameter int SETTLE_MS = 250
) (
   input  logic       Clk100MHz,
   input  logic       reset,
   input  logic       Clk1KHzEn,
   input  logic       RollBtn,
   input  logic       GameReady,
   output logic [2:0] Die1,
   output logic [2:0] Die2,
   output logic [3:0] DiceSum,
   output logic       DiceRolled,
   output logic       Busy
);

   typedef enum logic [1:0] {IDLE, SPIN, SETTLE, DONE} state_t;

   localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_MS - 1);

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  c1;
   logic [2:0]  c2;
   logic [11:0] settle_cnt;
   logic        btn_prev;
   logic        press;
   logic        settle_last;

   function automatic logic [2:0] die_inc(input logic [2:0] d);
      return (d == 3'd6) ? 3'd1 : d + 3'd1;
   endfunction

   function automatic logic [3:0] die_sum(input logic [2:0] a, input logic [2:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   assign press       = RollBtn && !btn_prev;
   assign settle_last = Clk1KHzEn && (settle_cnt == SETTLE_LAST);

   always_ff @(posedge Clk100MHz or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (press && GameReady) state_nxt = SPIN;
         SPIN:    if (!RollBtn)           state_nxt = SETTLE;
         SETTLE:  if (settle_last)        state_nxt = DONE;
         DONE:                            state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy       = (state != IDLE);
      DiceRolled = (state == DONE);
   end

   // DiceSum is loaded on the final settle tick so it is already valid while DiceRolled is high.
   always_ff @(posedge Clk100MHz or posedge reset) begin
      if (reset) begin
         btn_prev   <= 1'b1;
         c1         <= 3'd1;
         c2         <= 3'd1;
         settle_cnt <= '0;
         Die1       <= '0;
         Die2       <= '0;
         DiceSum    <= '0;
      end else begin
         btn_prev <= RollBtn;
         case (state)
            SPIN: begin
               if (!RollBtn) begin
                  Die1       <= c1;
                  Die2       <= c2;
                  settle_cnt <= '0;
               end else begin
                  c1 <= die_inc(c1);
                  if (c1 == 3'd6) c2 <= die_inc(c2);
                  if (Clk1KHzEn) begin
                     Die1 <= c1;
                     Die2 <= c2;
                  end
               end
            end
            SETTLE: begin
               if (Clk1KHzEn) begin
                  settle_cnt <= settle_cnt + 12'd1;
                  if (settle_last) DiceSum <= die_sum(Die1, Die2);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with a 2-tick settle delay.
module tb_dice_roll_ctrl;

   logic       Clk100MHz = 1'b0;
   logic       reset;
   logic       Clk1KHzEn;
   logic       RollBtn;
   logic       GameReady;
   logic [2:0] Die1;
   logic [2:0] Die2;
   logic [3:0] DiceSum;
   logic       DiceRolled;
   logic       Busy;

   int tests  = 0;
   int fails  = 0;
   int pulses = 0;
   int p0;

   dice_roll_ctrl #(.SETTLE_MS(2)) dut (
      .Clk100MHz (Clk100MHz),
      .reset     (reset),
      .Clk1KHzEn (Clk1KHzEn),
      .RollBtn   (RollBtn),
      .GameReady (GameReady),
      .Die1      (Die1),
      .Die2      (Die2),
      .DiceSum   (DiceSum),
      .DiceRolled(DiceRolled),
      .Busy      (Busy)
   );

   always #5 Clk100MHz = ~Clk100MHz;

   always @(negedge Clk100MHz) if (DiceRolled === 1'b1) pulses <= pulses + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge Clk100MHz);
         #1;
      end
   endtask

   task automatic tick();
      Clk1KHzEn = 1'b1;
      cyc();
      Clk1KHzEn = 1'b0;
   endtask

   task automatic settle_chk(input logic [3:0] esum);
      tick();
      cyc(2);
      chk("settle_rolled", DiceRolled, 0);
      chk("settle_busy", Busy, 1);
      tick();
      chk("done_rolled", DiceRolled, 1);
      chk("done_sum", DiceSum, esum);
      chk("done_busy", Busy, 1);
      cyc();
      chk("idle_rolled", DiceRolled, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_sum_held", DiceSum, esum);
      cyc();
   endtask

   task automatic do_roll(input int n, input logic [2:0] e1, input logic [2:0] e2,
                          input logic [3:0] esum);
      RollBtn = 1'b1;
      cyc();
      chk("spin_busy", Busy, 1);
      cyc(n);
      RollBtn = 1'b0;
      cyc();
      chk("final_die1", Die1, e1);
      chk("final_die2", Die2, e2);
      settle_chk(esum);
   endtask

   initial begin
      // T1: reset with button held
      reset = 1'b1; RollBtn = 1'b1; GameReady = 1'b1; Clk1KHzEn = 1'b0;
      cyc(3);
      chk("rst_die1", Die1, 0);
      chk("rst_die2", Die2, 0);
      chk("rst_sum", DiceSum, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_rolled", DiceRolled, 0);
      reset = 1'b0;
      cyc(3);
      chk("held_through_reset_busy", Busy, 0);
      RollBtn = 1'b0;
      cyc();

      // T2: 8 increments with a tumble tick after 3 -> (3,2), sum 5
      RollBtn = 1'b1;
      cyc();
      chk("t2_spin_busy", Busy, 1);
      cyc(3);
      tick();
      chk("t2_tumble_die1", Die1, 4);
      chk("t2_tumble_die2", Die2, 1);
      cyc(4);
      RollBtn = 1'b0;
      cyc();
      chk("t2_die1", Die1, 3);
      chk("t2_die2", Die2, 2);
      chk("t2_settle_busy", Busy, 1);
      settle_chk(4'd5);

      // T3: max sum then wrap of both counters
      reset = 1'b1;
      cyc();
      chk("t3_rst_sum", DiceSum, 0);
      cyc();
      reset = 1'b0;
      cyc();
      do_roll(35, 3'd6, 3'd6, 4'hC);
      do_roll(1, 3'd1, 3'd1, 4'd2);

      // T4: press without GameReady is discarded, not queued
      p0 = pulses;
      GameReady = 1'b0;
      RollBtn = 1'b1;
      cyc();
      chk("t4_busy_a", Busy, 0);
      cyc(3);
      chk("t4_busy_b", Busy, 0);
      GameReady = 1'b1;
      cyc(3);
      chk("t4_busy_c", Busy, 0);
      chk("t4_no_pulse", pulses - p0, 0);
      RollBtn = 1'b0;
      cyc(2);

      // T5: re-press during SETTLE is ignored; held button in IDLE starts nothing
      p0 = pulses;
      RollBtn = 1'b1;
      cyc();
      cyc(4);
      RollBtn = 1'b0;
      cyc();
      chk("t5_die1", Die1, 5);
      chk("t5_die2", Die2, 1);
      RollBtn = 1'b1;
      cyc(2);
      tick();
      cyc(2);
      chk("t5_settle_busy", Busy, 1);
      chk("t5_settle_rolled", DiceRolled, 0);
      tick();
      chk("t5_rolled", DiceRolled, 1);
      chk("t5_sum", DiceSum, 6);
      cyc(6);
      chk("t5_idle_busy", Busy, 0);
      chk("t5_one_pulse", pulses - p0, 1);
      RollBtn = 1'b0;
      cyc(2);

      // T6: reset mid-SETTLE aborts the roll and restores counters
      RollBtn = 1'b1;
      cyc();
      cyc(2);
      RollBtn = 1'b0;
      cyc();
      chk("t6_die1", Die1, 1);
      chk("t6_die2", Die2, 2);
      tick();
      p0 = pulses;
      reset = 1'b1;
      #1;
      chk("t6_rst_die1", Die1, 0);
      chk("t6_rst_die2", Die2, 0);
      chk("t6_rst_sum", DiceSum, 0);
      chk("t6_rst_busy", Busy, 0);
      cyc(2);
      reset = 1'b0;
      tick();
      cyc(3);
      chk("t6_no_pulse", pulses - p0, 0);
      chk("t6_idle_busy", Busy, 0);
      do_roll(8, 3'd3, 3'd2, 4'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
